// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC, synchronous-read IMEM, 1-entry skid buffer and valid/ready output.
// Optional feature macro IMEM_LOAD_EN: enables IMEM writes through the load_* port.
module instr_fetch #(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter string       MEM_INIT = ""
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              hold,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    input  logic              instr_ready,
    output logic              instr_valid,
    output logic [31:0]       instruction,
    output logic [31:0]       pc,
    output logic              fault,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HOLD,
        ST_FAULT
    } state_t;

    state_t      state_q, state_d;

    logic [31:0] fetch_pc;
    logic        out_valid;
    logic [31:0] out_instr, out_pc;
    logic        skid_valid;
    logic [31:0] skid_instr, skid_pc;
    logic        inflight;
    logic [31:0] inflight_pc;
    logic [31:0] rdata;
    logic [31:0] mem [DEPTH];

    logic misaligned, flush, load_pc, issue, stalled;

    // Contents start at zero.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

    // NOTE: every signal gets a default before the decisions, so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        flush      = 1'b0;
        load_pc    = 1'b0;
        misaligned = redirect && (redirect_pc[1:0] != 2'b00);
        stalled    = out_valid && !instr_ready;
        if (state_q != ST_FAULT) begin
            if (misaligned) begin
                state_d = ST_FAULT;
                flush   = 1'b1;
            end else begin
                state_d = hold ? ST_HOLD : ST_RUN;
                load_pc = redirect;
                // While holding, a redirect only retargets; queued words still drain.
                flush   = redirect && (state_q == ST_RUN);
            end
        end
        issue = (state_q == ST_RUN) && !redirect && !skid_valid && !(inflight && stalled);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (!resetn) state_q <= ST_RUN;
        else         state_q <= state_d;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            fetch_pc    <= RESET_PC;
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_pc      <= '0;
            skid_valid  <= 1'b0;
            skid_instr  <= '0;
            skid_pc     <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            if (load_pc)    fetch_pc <= redirect_pc;
            else if (issue) fetch_pc <= fetch_pc + 32'd4;

            inflight <= issue;
            if (issue) inflight_pc <= fetch_pc;

            if (flush) begin
                out_valid  <= 1'b0;
                skid_valid <= 1'b0;
            end else if (!stalled) begin
                // Output frees up: the older skid word goes first, the returning word queues behind it.
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    out_instr  <= skid_instr;
                    out_pc     <= skid_pc;
                    skid_valid <= inflight;
                    skid_instr <= rdata;
                    skid_pc    <= inflight_pc;
                end else begin
                    out_valid <= inflight;
                    if (inflight) begin
                        out_instr <= rdata;
                        out_pc    <= inflight_pc;
                    end
                end
            end else if (inflight) begin
                skid_valid <= 1'b1;
                skid_instr <= rdata;
                skid_pc    <= inflight_pc;
            end
        end
    end

    // NOTE: the memory array is never reset; only the control state around it is.
    always_ff @(posedge clock) begin
`ifdef IMEM_LOAD_EN
        if (load_we) mem[load_addr] <= load_data;
`endif
        if (issue) rdata <= mem[fetch_pc[ADDR_W+1:2]];
    end

`ifndef IMEM_LOAD_EN
    logic unused_load;
    assign unused_load = ^{load_we, load_addr, load_data};
`endif

    assign instr_valid = out_valid;
    assign instruction = out_instr;
    assign pc          = out_pc;
    assign fault       = (state_q == ST_FAULT);

endmodule
